demultiplexor6_seq: RTL
=======================

DEMULTIPLEXOR6_SEQ -- requirements
Module: demultiplexor6_seq

Interface
REQ-001 Parameter SEL_W, default 6: destination address width; the bank width is N = 2**SEL_W (64 at default).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  producer offers in_bit this cycle.
REQ-005 in_ready  output  1  block can accept in_bit this cycle.
REQ-006 in_bit  input  1  data bit to route to one bank position.
REQ-007 sel  input  SEL_W  destination index, used in direct mode.
REQ-008 auto_mode  input  1  1 = destination from internal pointer; 0 = destination from sel.
REQ-009 clear  input  1  synchronous clear of bank, pointer and frame state.
REQ-010 frame_ack  input  1  consumer has taken the completed frame.
REQ-011 out  output  N  registered bank; out[i] is routed bit i.
REQ-012 frame_valid  output  1  complete auto-mode frame held on out.
REQ-013 ptr  output  SEL_W  current auto-mode write index.

Function
REQ-014 Accept = in_valid & in_ready; all behaviour below is evaluated at the rising edge of clk.
REQ-015 The state machine SHALL have two states: FILL (in_ready=1, frame_valid=0) and HOLD (in_ready=0, frame_valid=1).
REQ-016 In both states, in_ready and frame_valid SHALL be decoded from the state register only, with no combinational path from any input.
REQ-017 On accept with auto_mode=0: out[sel] <= in_bit; all other bits, ptr and state unchanged.
REQ-018 On accept with auto_mode=1: out[ptr] <= in_bit and ptr <= ptr+1, modulo N.
REQ-019 An auto-mode accept with ptr = N-1 SHALL wrap ptr to 0 and move the state to HOLD.
REQ-020 A direct-mode accept SHALL never change state, regardless of the ptr value.
REQ-021 A write SHALL be visible on out in the cycle after the accept (latency 1).
REQ-022 frame_valid SHALL rise in the cycle after the N-th auto-mode accept.
REQ-023 In HOLD, out SHALL be frozen and in_valid SHALL be ignored.
REQ-024 In HOLD, frame_ack=1 SHALL move the state to FILL.
REQ-025 Leaving HOLD SHALL NOT alter out; ptr is already 0.
REQ-026 In FILL, frame_ack SHALL be ignored.
REQ-027 clear=1 SHALL set out to 0, ptr to 0 and state to FILL, with priority over accept and frame_ack in the same cycle.
REQ-028 Mixing modes within a frame SHALL be legal: direct writes may overwrite any bit, and only auto accepts advance ptr.
REQ-029 The auto_mode value SHALL be sampled per accept; toggling it between accepts SHALL have no other effect.

Reset
REQ-030 While rst=1: out=0, ptr=0, state=FILL, in_ready=1, frame_valid=0, effective at the next clock edge.
REQ-031 rst SHALL have priority over clear, accept and frame_ack.
REQ-032 rst asserted mid-frame or in HOLD SHALL discard the partial or held frame.

Verification
REQ-033 Reset, then direct writes in_bit=1 to sel=0, 5 and 63 -> out = 0x8000_0000_0000_0021 one cycle after the last write; frame_valid=0; ptr=0.
REQ-034 Reset, then 64 back-to-back auto accepts with in_bit pattern 0xDEAD_BEEF_0123_4567 (LSB first) -> the cycle after the 64th accept: frame_valid=1, in_ready=0, out=0xDEAD_BEEF_0123_4567, ptr=0.
REQ-035 In HOLD, drive in_valid=1 with in_bit=0 and sel=0 for 3 cycles, then frame_ack=1 -> out unchanged throughout; FILL next cycle with in_ready=1, frame_valid=0.
REQ-036 10 auto accepts, then clear=1 together with in_valid=1 -> next cycle: out=0, ptr=0, no write occurred; the next auto accept lands in out[0].
REQ-037 rst=1 asserted during HOLD with frame_ack=1 in the same cycle -> next cycle: out=0, state FILL, frame_valid=0.
REQ-038 Random in_valid/auto_mode/sel stimulus against a reference model -> out, ptr and frame_valid match the model on every cycle.

Source files
------------

// File: rtl/demultiplexor6_seq.sv
// Sequential 1-to-N bit demultiplexor with a registered output bank.
// Auto mode fills the bank as a frame that is held until acknowledged.
module demultiplexor6_seq #(
  parameter int SEL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  auto_mode,
  input  logic                  clear,
  input  logic                  frame_ack,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  frame_valid,
  output logic [SEL_W-1:0]      ptr
);

  localparam int N = 2 ** SEL_W;

  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;

  logic state;
  logic accept;

  // Handshake outputs come straight from the state register.
  assign in_ready    = (state == FILL);
  assign frame_valid = (state == HOLD);
  assign accept      = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      ptr   <= '0;
      state <= FILL;
    end else if (clear) begin
      out   <= '0;
      ptr   <= '0;
      state <= FILL;
    end else begin
      unique case (1'b1)
        accept && auto_mode: begin
          out[ptr] <= in_bit;
          ptr      <= ptr + SEL_W'(1);
          if (ptr == SEL_W'(N - 1)) begin
            state <= HOLD;
          end
        end
        accept && !auto_mode: begin
          out[sel] <= in_bit;
        end
        (state == HOLD) && frame_ack: begin
          state <= FILL;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
